// File: rtl/expect_mon_pkg.sv
// Shared types and constants for the a ##1 b ##1 c ##1 !c expect monitor.
// Hunt-window defaults exist only when EXPECT_MON_HUNT_EN is defined.
package expect_mon_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHK_A  = 3'd1,
        CHK_B  = 3'd2,
        CHK_C  = 3'd3,
        CHK_NC = 3'd4
    } state_e;

    localparam logic [1:0] STG_A  = 2'd0;
    localparam logic [1:0] STG_B  = 2'd1;
    localparam logic [1:0] STG_C  = 2'd2;
    localparam logic [1:0] STG_NC = 2'd3;

    localparam int unsigned CNT_W_DEF = 8;
`ifdef EXPECT_MON_HUNT_EN
    localparam int unsigned TIMEOUT_DEF   = 20000;
    localparam int unsigned TIMEOUT_W_DEF = 15;
`endif

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/expect_seq_monitor.sv
// Single-attempt monitor for a ##1 b ##1 c ##1 !c with pass/fail tallies.
// Define EXPECT_MON_HUNT_EN to let CHK_A wait up to TIMEOUT samples for a.
module expect_seq_monitor
    import expect_mon_pkg::*;
#(
`ifdef EXPECT_MON_HUNT_EN
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF,
`endif
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             clr_cnt,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_stage,
    output logic             arm_ovr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    state_e     state_q;
    state_e     state_d;
    logic       done_d;
    logic       pass_d;
    logic       fail_d;
    logic [1:0] stage_d;
    logic       arm_ovr_d;
    logic       a_miss;

`ifdef EXPECT_MON_HUNT_EN
    logic [TIMEOUT_W-1:0] hunt_cnt;
    logic                 hunt_last;

    assign hunt_last = (hunt_cnt == TIMEOUT_W'(TIMEOUT - 1));
    assign a_miss    = ~a & hunt_last;

    // Counts missed samples while hunting; held at zero outside CHK_A so entry starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hunt_cnt <= '0;
        end else if (state_q != CHK_A) begin
            hunt_cnt <= '0;
        end else if (!a) begin
            hunt_cnt <= hunt_cnt + TIMEOUT_W'(1);
        end
    end
`else
    assign a_miss = ~a;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_stage <= STG_A;
            arm_ovr    <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d != IDLE);
            done       <= done_d;
            pass       <= pass_d;
            fail       <= fail_d;
            fail_stage <= stage_d;
            arm_ovr    <= arm_ovr_d;
        end
    end

    // Next-state logic: advance on each true sample, return to IDLE on a miss.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm) state_d = CHK_A;
            CHK_A: begin
                if (a)           state_d = CHK_B;
                else if (a_miss) state_d = IDLE;
            end
            CHK_B:   state_d = b ? CHK_C : IDLE;
            CHK_C:   state_d = c ? CHK_NC : IDLE;
            CHK_NC:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; fail_stage only moves when an attempt fails.
    always_comb begin
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        stage_d   = fail_stage;
        arm_ovr_d = arm && (state_q != IDLE);
        case (state_q)
            CHK_A: if (!a && a_miss) begin
                fail_d  = 1'b1;
                stage_d = STG_A;
            end
            CHK_B: if (!b) begin
                fail_d  = 1'b1;
                stage_d = STG_B;
            end
            CHK_C: if (!c) begin
                fail_d  = 1'b1;
                stage_d = STG_C;
            end
            CHK_NC: begin
                if (c) begin
                    fail_d  = 1'b1;
                    stage_d = STG_NC;
                end else begin
                    pass_d = 1'b1;
                end
            end
            default: ;
        endcase
        done_d = pass_d | fail_d;
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (pass),
        .cnt   (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (fail),
        .cnt   (fail_cnt)
    );

endmodule

// File: tb/tb_expect_seq_monitor.sv
// Directed bench for expect_seq_monitor: a wide-counter and a 2-bit-counter instance share stimulus.
module tb_expect_seq_monitor;

    logic clk = 1'b0;
    logic rst_n, arm, clr_cnt, a, b, c;

    logic       busy, done, pass, fail, arm_ovr;
    logic [1:0] fail_stage;
    logic [7:0] pass_cnt, fail_cnt;

    logic       busy2, done2, pass2, fail2, arm_ovr2;
    logic [1:0] fail_stage2;
    logic [1:0] pass_cnt2, fail_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    expect_seq_monitor #(
`ifdef EXPECT_MON_HUNT_EN
        .TIMEOUT   (8),
        .TIMEOUT_W (4),
`endif
        .CNT_W     (8)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clr_cnt(clr_cnt),
        .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_stage(fail_stage), .arm_ovr(arm_ovr),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    expect_seq_monitor #(
`ifdef EXPECT_MON_HUNT_EN
        .TIMEOUT   (8),
        .TIMEOUT_W (4),
`endif
        .CNT_W     (2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clr_cnt(clr_cnt),
        .a(a), .b(b), .c(c),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
        .fail_stage(fail_stage2), .arm_ovr(arm_ovr2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every input asserted
        rst_n = 1'b0; arm = 1'b1; clr_cnt = 1'b0; a = 1'b1; b = 1'b1; c = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_arm_ovr", 32'(arm_ovr), 0);
        chk("rst_pass_cnt", 32'(pass_cnt), 0);
        chk("rst_fail_cnt", 32'(fail_cnt), 0);
        chk("rst_fail_stage", 32'(fail_stage), 0);

        rst_n = 1'b1; arm = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Full match
        arm = 1'b1; tick();
        chk("p_busy_k", 32'(busy), 1);
        arm = 1'b0; a = 1'b1; tick();
        a = 1'b0; b = 1'b1; tick();
        chk("p_done_k2", 32'(done), 0);
        b = 1'b0; c = 1'b1; tick();
        c = 1'b0; tick();
        chk("p_pass", 32'(pass), 1);
        chk("p_done", 32'(done), 1);
        chk("p_fail", 32'(fail), 0);
        chk("p_busy_end", 32'(busy), 0);
        tick();
        chk("p_pass_pulse", 32'(pass), 0);
        chk("p_done_pulse", 32'(done), 0);
        chk("p_pass_cnt", 32'(pass_cnt), 1);
        chk("p_fail_cnt", 32'(fail_cnt), 0);

        // Fail at stage B
        arm = 1'b1; tick();
        arm = 1'b0; a = 1'b1; tick();
        a = 1'b0; b = 1'b0; tick();
        chk("fb_fail", 32'(fail), 1);
        chk("fb_done", 32'(done), 1);
        chk("fb_pass", 32'(pass), 0);
        chk("fb_stage", 32'(fail_stage), 1);
        tick();
        chk("fb_fail_cnt", 32'(fail_cnt), 1);
        chk("fb_stage_held", 32'(fail_stage), 1);

        // Fail at stage NOT_C (c held high)
        arm = 1'b1; tick();
        arm = 1'b0; a = 1'b1; tick();
        a = 1'b0; b = 1'b1; tick();
        b = 1'b0; c = 1'b1; tick();
        chk("fnc_busy_k3", 32'(busy), 1);
        tick();
        chk("fnc_fail", 32'(fail), 1);
        chk("fnc_stage", 32'(fail_stage), 3);
        c = 1'b0;

        // Fail at stage C, armed back-to-back in the done cycle
        arm = 1'b1; tick();
        chk("b2b_busy", 32'(busy), 1);
        chk("fnc_fail_cnt", 32'(fail_cnt), 2);
        arm = 1'b0; a = 1'b1; tick();
        a = 1'b0; b = 1'b1; tick();
        b = 1'b0; c = 1'b0; tick();
        chk("fc_fail", 32'(fail), 1);
        chk("fc_stage", 32'(fail_stage), 2);
        tick();
        chk("fc_fail_cnt", 32'(fail_cnt), 3);
        chk("fc_fail_cnt2", 32'(fail_cnt2), 3);
        chk("fc_pass_cnt", 32'(pass_cnt), 1);

        // Overrun arm at k+2; original attempt still passes
        arm = 1'b1; tick();
        arm = 1'b0; a = 1'b1; tick();
        chk("ovr_none_k1", 32'(arm_ovr), 0);
        arm = 1'b1; a = 1'b0; b = 1'b1; tick();
        chk("ovr_pulse", 32'(arm_ovr), 1);
        arm = 1'b0; b = 1'b0; c = 1'b1; tick();
        chk("ovr_clear", 32'(arm_ovr), 0);
        chk("ovr_busy", 32'(busy), 1);
        c = 1'b0; tick();
        chk("ovr_pass", 32'(pass), 1);
        chk("ovr_pass_cnt_k4", 32'(pass_cnt), 1);

        // clr_cnt in the pass cycle wins; a new attempt is armed in the same cycle
        clr_cnt = 1'b1; arm = 1'b1; tick();
        chk("clr_pass_cnt", 32'(pass_cnt), 0);
        chk("clr_fail_cnt", 32'(fail_cnt), 0);
        chk("clr_b2b_busy", 32'(busy), 1);
        clr_cnt = 1'b0; arm = 1'b0; a = 1'b1; tick();
        a = 1'b0; b = 1'b1; tick();
        b = 1'b0; c = 1'b1; tick();
        c = 1'b0; tick();
        chk("clr_next_pass", 32'(pass), 1);
        tick();
        chk("clr_next_pass_cnt", 32'(pass_cnt), 1);

        // Five stage-B failures: narrow counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            arm = 1'b1; tick();
            arm = 1'b0; a = 1'b1; tick();
            a = 1'b0; b = 1'b0; tick();
        end
        tick();
        chk("sat_fail_cnt8", 32'(fail_cnt), 5);
        chk("sat_fail_cnt2", 32'(fail_cnt2), 3);
        chk("sat_pass_cnt2", 32'(pass_cnt2), 1);

`ifdef EXPECT_MON_HUNT_EN
        // Hunt: a low for 5 samples, then the full sequence
        arm = 1'b1; tick();
        arm = 1'b0; a = 1'b0;
        repeat (5) tick();
        chk("hunt_busy", 32'(busy), 1);
        chk("hunt_no_done", 32'(done), 0);
        a = 1'b1; tick();
        a = 1'b0; b = 1'b1; tick();
        b = 1'b0; c = 1'b1; tick();
        c = 1'b0; tick();
        chk("hunt_pass", 32'(pass), 1);
        tick();

        // Hunt timeout: done after edge k+8
        arm = 1'b1; tick();
        arm = 1'b0; a = 1'b0;
        repeat (7) tick();
        chk("to_no_done_k7", 32'(done), 0);
        chk("to_busy_k7", 32'(busy), 1);
        tick();
        chk("to_fail", 32'(fail), 1);
        chk("to_done", 32'(done), 1);
        chk("to_stage", 32'(fail_stage), 0);
        tick();
`else
        // Strict: a low at the first sample fails at stage A
        arm = 1'b1; tick();
        arm = 1'b0; a = 1'b0; tick();
        chk("sa_fail", 32'(fail), 1);
        chk("sa_done", 32'(done), 1);
        chk("sa_stage", 32'(fail_stage), 0);
        chk("sa_busy", 32'(busy), 0);
        tick();
`endif

        // Reset at k+2 aborts silently
        arm = 1'b1; tick();
        arm = 1'b0; a = 1'b1; tick();
        a = 1'b0; b = 1'b1; rst_n = 1'b0; tick();
        chk("ra_busy", 32'(busy), 0);
        chk("ra_done", 32'(done), 0);
        chk("ra_fail_cnt", 32'(fail_cnt), 0);
        chk("ra_pass_cnt", 32'(pass_cnt), 0);
        chk("ra_fail_cnt2", 32'(fail_cnt2), 0);
        rst_n = 1'b1; b = 1'b0; c = 1'b1; tick();
        chk("ra_done_k3", 32'(done), 0);
        c = 1'b0; tick();
        chk("ra_done_k4", 32'(done), 0);
        tick();
        chk("ra_done_k5", 32'(done), 0);
        chk("ra_busy_after", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
